// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 Hz raster timing, derived totals and sync windows,
// plus the small types/helpers shared by the raster generator.
package vga_timing_pkg;

  // Width of the x/y raster coordinates
  localparam int unsigned COORD_W = 10;

  // Default horizontal timing (pixels)
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  // Default vertical timing (lines)
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Derived totals: 800 pixels per line, 525 lines per frame
  localparam int unsigned DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync windows, half-open [START, END): x = 656..751, y = 490..491
  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Bundle carried through the output delay line (MSB first)
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_bus_t;

  localparam int unsigned SYNC_BUS_W = $bits(sync_bus_t);

  // Map an "inside the sync window" flag onto the board sync level
  function automatic logic sync_level(input logic active, input logic pol);
    if (active) begin
      return pol;
    end else begin
      return ~pol;
    end
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset to a chosen idle
// vector. Depth 0 degenerates to a plain wire so the caller can remove
// the pipeline delay entirely without changing its own structure.
module sync_delay_line #(
  parameter int unsigned           WIDTH   = 1,
  parameter int unsigned           DEPTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // clk/reset have no work to do without stages
      logic w_unused_ok;
      assign w_unused_ok = clk | reset;
      assign dout        = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift the bundle one stage per clock; reset flushes every stage to idle
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= RST_VAL;
          end
        end else begin
          r_stage[0] <= din;
          for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the text display path. Produces the pixel
// coordinates and active-area flag for the display block with no latency,
// and the board sync/blank signals delayed to line up with the RGB
// pipeline behind the glyph ROM.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N
);

  // Timing constants narrowed to the coordinate width
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_VISEND = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] Y_VISEND = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] COORD_0  = COORD_W'(0);
  localparam logic [COORD_W-1:0] COORD_1  = COORD_W'(1);

  // Idle pattern loaded into every delay stage on reset: syncs inactive, blanked
  localparam sync_bus_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank_n: 1'b0};

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  logic      w_video_on;
  logic      w_hs_window;
  logic      w_vs_window;
  sync_bus_t w_raw;
  sync_bus_t w_dly;

  // Free-running raster counters; reset restarts the frame at (0,0) at once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= COORD_0;
      r_y <= COORD_0;
    end else if (r_x == X_LAST) begin
      r_x <= COORD_0;
      if (r_y == Y_LAST) begin
        r_y <= COORD_0;
      end else begin
        r_y <= r_y + COORD_1;
      end
    end else begin
      r_x <= r_x + COORD_1;
    end
  end

  // Decodes straight off the counter registers so they align with x/y
  assign w_video_on  = (r_x < X_VISEND) && (r_y < Y_VISEND);
  assign w_hs_window = (r_x >= HS_START) && (r_x < HS_END);
  assign w_vs_window = (r_y >= VS_START) && (r_y < VS_END);

  assign w_raw = '{
    hs:      sync_level(w_hs_window, SYNC_POL),
    vs:      sync_level(w_vs_window, SYNC_POL),
    blank_n: w_video_on
  };

  // Align board sync/blank with the RGB pipeline latency
  sync_delay_line #(
    .WIDTH   (SYNC_BUS_W),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   (w_raw),
    .dout  (w_dly)
  );

  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = w_video_on;
  assign line_start  = (r_x == COORD_0);
  assign frame_start = (r_x == COORD_0) && (r_y == COORD_0);
  assign VGA_HS      = w_dly.hs;
  assign VGA_VS      = w_dly.vs;
  assign VGA_BLANK_N = w_dly.blank_n;
  // No sync-on-green
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. u_dut uses the full 640x480 timing;
// u_sm and u_z use a shrunken raster (50 x 19, sync x=36..43, y=14..15)
// so whole frames fit in a short run. u_z has zero sync delay.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #20 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y, z_x, z_y;
  logic d_von, d_ls, d_fs, d_hs, d_vs, d_bn, d_sn;
  logic s_von, s_ls, s_fs, s_hs, s_vs, s_bn, s_sn;
  logic z_von, z_ls, z_fs, z_hs, z_vs, z_bn, z_sn;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  vga_timing_gen u_dut (
    .clk(clk), .reset(reset), .x(d_x), .y(d_y), .video_on(d_von),
    .line_start(d_ls), .frame_start(d_fs), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn));

  vga_timing_gen #(
    .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(2)
  ) u_sm (
    .clk(clk), .reset(reset), .x(s_x), .y(s_y), .video_on(s_von),
    .line_start(s_ls), .frame_start(s_fs), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn));

  vga_timing_gen #(
    .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(0)
  ) u_z (
    .clk(clk), .reset(reset), .x(z_x), .y(z_y), .video_on(z_von),
    .line_start(z_ls), .frame_start(z_fs), .VGA_HS(z_hs), .VGA_VS(z_vs),
    .VGA_BLANK_N(z_bn), .VGA_SYNC_N(z_sn));

  // Count one comparison and report it if observed differs from expected
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one pixel clock; sampling happens on the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Shrunken-raster reference: raw sync/blank at a frame-relative index
  function automatic logic sm_hs(input int rel);
    int xr;
    xr = rel % 50;
    return (xr >= 36 && xr < 44) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic sm_vs(input int rel);
    int yr;
    yr = rel / 50;
    return (yr >= 14 && yr < 16) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic sm_bn(input int rel);
    return ((rel % 50) < 32 && (rel / 50) < 12) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    int nfall, fall_prev, low_cnt, vs_run, last_fs, ymax, rel, rd;
    logic prev_hs;

    // ---- Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_x", d_x, 0);
      chk("rst_y", d_y, 0);
      chk("rst_video_on", d_von, 1);
      chk("rst_line_start", d_ls, 1);
      chk("rst_frame_start", d_fs, 1);
      chk("rst_hs", d_hs, 1);
      chk("rst_vs", d_vs, 1);
      chk("rst_blank_n", d_bn, 0);
      chk("rst_sync_n", d_sn, 0);
    end
    reset = 1'b0;
    cyc   = 0;
    chk("rel0_x", d_x, 0);
    chk("rel0_frame_start", d_fs, 1);
    chk("rel0_hs", d_hs, 1);
    chk("rel0_blank_n", d_bn, 0);
    tick();
    chk("rel1_x", d_x, 1);
    chk("rel1_hs", d_hs, 1);
    chk("rel1_blank_n", d_bn, 0);
    chk("rel1_frame_start", d_fs, 0);
    tick();
    chk("rel2_x", d_x, 2);
    chk("rel2_blank_n", d_bn, 1);

    // ---- Line / active-area boundaries
    run_to(639);
    chk("x639_x", d_x, 639);
    chk("x639_y", d_y, 0);
    chk("x639_video_on", d_von, 1);
    tick();
    chk("x640_x", d_x, 640);
    chk("x640_video_on", d_von, 0);
    run_to(4799);
    chk("x799_x", d_x, 799);
    chk("x799_y", d_y, 5);
    chk("x799_line_start", d_ls, 0);
    tick();
    chk("wrap_x", d_x, 0);
    chk("wrap_y", d_y, 6);
    chk("wrap_line_start", d_ls, 1);
    chk("wrap_frame_start", d_fs, 0);

    // ---- Horizontal sync on the full-size raster
    run_to(5400);
    nfall = 0; fall_prev = 0; low_cnt = 0;
    prev_hs = d_hs;
    for (int i = 1; i <= 1700; i++) begin
      tick();
      if (i <= 800 && d_hs == 1'b0) low_cnt++;
      if (d_hs == 1'b0 && prev_hs == 1'b1) begin
        nfall++;
        if (nfall == 1) begin
          chk("hs_first_fall_cyc", cyc, 5458);
          chk("hs_first_fall_x", d_x, 658);
        end else begin
          chk("hs_fall_period", cyc - fall_prev, 800);
        end
        fall_prev = cyc;
      end
      prev_hs = d_hs;
    end
    chk("hs_low_cycles", low_cnt, 96);
    chk("hs_fall_count", nfall, 3);
    chk("vs_idle_early_lines", d_vs, 1);

    // ---- Shrunken raster: full frames, vertical sync, zero-delay copy
    vs_run = 0; last_fs = -1; ymax = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      rel = cyc % 950;
      rd  = (cyc - 2) % 950;
      chk("z_hs", z_hs, sm_hs(rel));
      chk("z_vs", z_vs, sm_vs(rel));
      chk("z_blank_n", z_bn, sm_bn(rel));
      chk("s_x", s_x, rel % 50);
      chk("s_y", s_y, rel / 50);
      chk("s_hs", s_hs, sm_hs(rd));
      chk("s_vs", s_vs, sm_vs(rd));
      chk("s_blank_n", s_bn, sm_bn(rd));
      if (rel == 581) chk("s_last_vis_line_on", s_von, 1);
      if (rel == 600) begin
        chk("s_first_blank_line_off", s_von, 0);
        chk("s_first_blank_line_ls", s_ls, 1);
      end
      if (s_vs == 1'b0) begin
        vs_run++;
      end else if (vs_run > 0) begin
        chk("s_vs_low_run", vs_run, 100);
        vs_run = 0;
      end
      if (s_fs == 1'b1) begin
        if (last_fs >= 0) chk("s_frame_period", cyc - last_fs, 950);
        last_fs = cyc;
      end
      if (int'(s_y) > ymax) ymax = int'(s_y);
    end
    chk("s_y_max", ymax, 18);

    // ---- Reset mid-frame on the full-size raster at (300, 11)
    chk("pre_mid_rst_x", d_x, 300);
    chk("pre_mid_rst_y", d_y, 11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    chk("mid_rst_x", d_x, 0);
    chk("mid_rst_y", d_y, 0);
    chk("mid_rst_frame_start", d_fs, 1);
    chk("mid_rst_blank_n", d_bn, 0);
    chk("mid_rst_hs", d_hs, 1);
    chk("mid_rst_s_x", s_x, 0);
    chk("mid_rst_z_blank_n", z_bn, 1);
    tick();
    chk("mid_rel1_x", d_x, 1);
    chk("mid_rel1_blank_n", d_bn, 0);
    tick();
    chk("mid_rel2_blank_n", d_bn, 1);
    run_to(801);
    chk("mid_resume_x", d_x, 1);
    chk("mid_resume_y", d_y, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster stage for the text display path: generates the 640x480@60 Hz pixel coordinates (x, y), the active-area flag (video_on) and the board-level sync and blank signals from the 25 MHz pixel clock. x, y and video_on feed the text/register display block directly. The sync and blank signals are delayed by a configurable number of cycles so they stay aligned with the display pipeline's RGB output (ROM and glyph latency).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
SYNC_DELAY, 2, pipeline delay (cycles, 0..7) applied to VGA_HS, VGA_VS and VGA_BLANK_N

Ports:
clk  input  1  25 MHz pixel clock; the block's only clock
reset  input  1  synchronous, active-high reset
x  output  10  horizontal pixel count, 0..H_TOTAL-1
y  output  10  vertical line count, 0..V_TOTAL-1
video_on  output  1  high when x < H_VISIBLE and y < V_VISIBLE
line_start  output  1  one-cycle pulse when x == 0
frame_start  output  1  one-cycle pulse when x == 0 and y == 0
VGA_HS  output  1  delayed horizontal sync
VGA_VS  output  1  delayed vertical sync
VGA_BLANK_N  output  1  delayed video_on
VGA_SYNC_N  output  1  tied to 0 (no sync-on-green)

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 525.
- Counters:
  - x and y are registers.
  - Each clk, x increments. At x == H_TOTAL-1, x wraps to 0 and y increments.
  - At x == H_TOTAL-1 and y == V_TOTAL-1, both x and y wrap to 0.
- Decoded outputs:
  - video_on, line_start and frame_start are decoded from the registered x and y.
  - They have zero latency relative to x and y: same cycle, no extra register.
- Raw sync (internal):
  - hs_raw is active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, i.e. x = 656..751.
  - vs_raw is active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, i.e. y = 490..491, for whole lines.
  - Active level is SYNC_POL.
- Delay line:
  - {hs_raw, vs_raw, video_on} pass through a SYNC_DELAY-stage shift register to VGA_HS, VGA_VS and VGA_BLANK_N.
  - With SYNC_DELAY = 0 the outputs are combinational copies of the raw signals.
- Reset:
  - Next edge: x = 0, y = 0.
  - Every delay-line stage loads the inactive value: HS/VS = ~SYNC_POL, BLANK_N = 0.
  - Hence, during reset and for SYNC_DELAY cycles after release, VGA_HS = VGA_VS = 1 and VGA_BLANK_N = 0 (default polarity).
  - During reset the decoded outputs follow x = y = 0, so video_on = 1, line_start = 1, frame_start = 1.
- Reset mid-frame: immediate restart of the raster at (0,0); no partial-line recovery; the delay line is flushed.
- No other inputs; the counters never stall.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_*/V_* above);
  - the derived H_TOTAL and V_TOTAL;
  - sync window start/end localparams;
  - the coordinate width (10).
- One sub-module, sync_delay_line: parameterised width and depth, synchronous reset to a parameterised reset vector, depth 0 acting as a pass-through. It is instantiated once with width 3.

Test Plan:
1. Reset timing: hold reset 3 cycles, then release.
   - During reset and at release: x = 0, y = 0, video_on = 1, frame_start = 1.
   - VGA_HS = 1 and VGA_BLANK_N = 0 for 2 cycles after release; VGA_BLANK_N = 1 on the 3rd cycle.
2. Line/active boundaries:
   - x = 639, y = 0 gives video_on = 1; next cycle x = 640 gives video_on = 0.
   - x = 799, y = 5 is followed by x = 0, y = 6 with line_start = 1.
   - y = 479 gives video_on = 1 for x < 640; y = 480 gives video_on = 0 for the whole line.
3. Horizontal sync: hs_raw is low exactly for x = 656..751 (96 cycles).
   - VGA_HS is low for 96 cycles, starting 2 cycles after x = 656.
   - The period between VGA_HS falling edges is 800 cycles.
4. Vertical sync and frame: VGA_VS is low for exactly 1600 consecutive cycles, spanning lines 490..491 (plus a 2-cycle offset).
   - frame_start pulses are exactly 420000 cycles apart.
   - y never exceeds 524.
5. Reset mid-frame: assert reset at x = 300, y = 200 for 1 cycle.
   - Next cycle: x = 0, y = 0, frame_start = 1, VGA_BLANK_N = 0.
   - Counting resumes normally.
6. Zero delay: with SYNC_DELAY = 0, VGA_HS equals hs_raw and VGA_BLANK_N equals video_on in the same cycle, across a full frame.
